reset_request_gen: RTL and testbench

- Upstream feeder of the staggered-reset-release stage.
- Turns the DE0 push button (raw, active-low, bouncy) and the game-logic game_over pulse into the 3-bit reset request vector that stage consumes.
- Requests are always all-ones or all-zeros, never partial, because downstream treats only 3'b111 as a reset request.
- Also issues one power-on request after reset_n deasserts.

---
 rtl/reset_flow_pkg.sv | 16 +
 rtl/key_debouncer.sv | 59 +++++
 rtl/reset_request_gen.sv | 121 ++++++++++++
 tb/tb_reset_request_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reset_flow_pkg.sv
// Types and constants shared by the reset request generator and the
// downstream staggered release stage.
package reset_flow_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
    PULSE        = 2'd2,
    WAIT_RELEASE = 2'd3
  } rst_state_e;

  // Downstream only recognises the all-ones pattern as a request.
  localparam logic [2:0] RST_REQ_ALL  = 3'b111;
  localparam logic [2:0] RST_REQ_NONE = 3'b000;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus stable-count debouncer for an active-low key.
// Emits the debounced level and one-cycle press/release strobes.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic press_evt,
  output logic release_evt
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press_evt;
  logic             r_release_evt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_flip;

  assign w_differ = (r_sync2 != r_level);
  assign w_flip   = w_differ && (r_cnt == DEB_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_level       <= 1'b1;
      r_press_evt   <= 1'b0;
      r_release_evt <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_sync1       <= key_n;
      r_sync2       <= r_sync1;
      // Strobes line up with the cycle in which the new level is visible.
      r_press_evt   <= w_flip && !r_sync2;
      r_release_evt <= w_flip && r_sync2;
      if (w_flip) begin
        r_level <= r_sync2;
      end
      if (!w_differ || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign level       = r_level;
  assign press_evt   = r_press_evt;
  assign release_evt = r_release_evt;

endmodule

// File: rtl/reset_request_gen.sv
// Turns a debounced long key press or a game_over pulse into an all-or-nothing
// 3-bit reset request pulse; also fires one request after power-on reset.
//
// state        | meaning
// IDLE         | no request, waiting for game_over or a debounced press
// HOLD         | key pressed, timing the hold before requesting a reset
// PULSE        | reset_req = 111 for PULSE_CYCLES clocks
// WAIT_RELEASE | request done, key still held; blocks auto-repeat
module reset_request_gen
  import reset_flow_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_n,
  input  logic       game_over,
  output logic [2:0] reset_req,
  output logic       busy
);

  // The press_evt cycle is the first hold cycle and HOLD is entered one clock
  // later, so HOLD terminates one count early to land the rise exactly
  // HOLD_CYCLES after press_evt.
  localparam logic [CNT_W-1:0] HOLD_LAST  =
    CNT_W'((HOLD_CYCLES >= 2) ? (HOLD_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             w_level;
  logic             w_press_evt;
  logic             w_release_evt;

  rst_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_req;
  logic             r_busy;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key_debouncer (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .level       (w_level),
    .press_evt   (w_press_evt),
    .release_evt (w_release_evt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PULSE;
      r_cnt   <= '0;
      r_req   <= RST_REQ_ALL;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (game_over) begin
            r_state <= PULSE;
            r_cnt   <= '0;
            r_req   <= RST_REQ_ALL;
            r_busy  <= 1'b1;
          end else if (w_press_evt) begin
            r_state <= HOLD;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (w_release_evt) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == HOLD_LAST) begin
            r_state <= PULSE;
            r_cnt   <= '0;
            r_req   <= RST_REQ_ALL;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PULSE: begin
          if (r_cnt == PULSE_LAST) begin
            r_cnt <= '0;
            r_req <= RST_REQ_NONE;
            if (!w_level) begin
              r_state <= WAIT_RELEASE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        WAIT_RELEASE: begin
          if (w_release_evt) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_req   <= RST_REQ_NONE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign reset_req = r_req;
  assign busy      = r_busy;

endmodule

// File: tb/tb_reset_request_gen.sv
// Directed scoreboard bench for reset_request_gen with short debounce/hold/pulse.
module tb_reset_request_gen;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int PUL  = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       key_n;
  logic       game_over;
  logic [2:0] reset_req;
  logic       busy;

  typedef struct {
    logic [2:0] req;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  reset_request_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .PULSE_CYCLES    (PUL),
    .CNT_W           (32)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_n     (key_n),
    .game_over (game_over),
    .reset_req (reset_req),
    .busy      (busy)
  );

  task automatic expect_push(input logic [2:0] req, input logic b, input string tag);
    exp_t e;
    e.req  = req;
    e.busy = b;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL sb_empty: no expectation queued at t=%0t", $time);
      return;
    end
    e = sb_q.pop_front();
    tests++;
    assert (reset_req === e.req) else begin
      fails++;
      $error("FAIL %s reset_req observed %b expected %b at t=%0t", e.tag, reset_req, e.req, $time);
    end
    tests++;
    assert (busy === e.busy) else begin
      fails++;
      $error("FAIL %s busy observed %b expected %b at t=%0t", e.tag, busy, e.busy, $time);
    end
  endtask

  task automatic cyc(input logic [2:0] req, input logic b, input string tag);
    expect_push(req, b, tag);
    @(posedge clock);
    #1;
    compare_pop();
  endtask

  task automatic now_chk(input logic [2:0] req, input logic b, input string tag);
    expect_push(req, b, tag);
    compare_pop();
  endtask

  // Key held low for edges 1..hold_len; expectations from timing arithmetic:
  // press_evt after edge DEB+2, HOLD from the next edge, release flips level
  // DEB+2 edges after the key goes high, IDLE one edge later.
  task automatic press_run(input int hold_len, input int total, input string tag);
    int         p;
    int         rel;
    bit         pulse;
    logic [2:0] req_e;
    logic       busy_e;
    p     = DEB + 2;
    rel   = hold_len + DEB + 2;
    pulse = (rel + 1 > p + HOLD);
    for (int k = 1; k <= total; k++) begin
      key_n  = (k <= hold_len) ? 1'b0 : 1'b1;
      busy_e = (k >= p + 1) && (k <= rel);
      req_e  = (pulse && k >= p + HOLD && k < p + HOLD + PUL) ? 3'b111 : 3'b000;
      cyc(req_e, busy_e, tag);
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    key_n     = 1'b1;
    game_over = 1'b0;
    #1 reset_n = 1'b0;
    #1;

    // power-on
    now_chk(3'b111, 1'b1, "por_async");
    repeat (5) cyc(3'b111, 1'b1, "por_hold");
    reset_n = 1'b1;
    now_chk(3'b111, 1'b1, "por_release");
    cyc(3'b111, 1'b1, "por_pulse");
    cyc(3'b111, 1'b1, "por_pulse");
    cyc(3'b000, 1'b0, "por_end");
    cyc(3'b000, 1'b0, "por_idle");

    // bouncing key never settles
    for (int i = 0; i < 40; i++) begin
      key_n = ((i >> 1) & 1) ? 1'b1 : 1'b0;
      cyc(3'b000, 1'b0, "bounce");
    end
    key_n = 1'b1;
    repeat (6) cyc(3'b000, 1'b0, "bounce_settle");

    press_run(15, 30, "short_press");
    press_run(60, 75, "long_press");

    // game_over from IDLE
    game_over = 1'b1;
    cyc(3'b111, 1'b1, "go_rise");
    game_over = 1'b0;
    cyc(3'b111, 1'b1, "go_pulse");
    cyc(3'b111, 1'b1, "go_pulse");
    cyc(3'b000, 1'b0, "go_end");
    cyc(3'b000, 1'b0, "go_idle");

    // second game_over mid-pulse must not extend it
    game_over = 1'b1;
    cyc(3'b111, 1'b1, "go2_rise");
    cyc(3'b111, 1'b1, "go2_mid");
    game_over = 1'b0;
    cyc(3'b111, 1'b1, "go2_pulse");
    cyc(3'b000, 1'b0, "go2_len");
    cyc(3'b000, 1'b0, "go2_idle");

    // game_over coincident with press_evt: PULSE, then WAIT_RELEASE
    for (int k = 1; k <= 30; k++) begin
      key_n     = (k <= 20) ? 1'b0 : 1'b1;
      game_over = (k == DEB + 3);
      if (k <= DEB + 2)
        cyc(3'b000, 1'b0, "go_press_pre");
      else if (k <= DEB + 2 + PUL)
        cyc(3'b111, 1'b1, "go_press_pulse");
      else if (k <= 20 + DEB + 2)
        cyc(3'b000, 1'b1, "go_press_wait");
      else
        cyc(3'b000, 1'b0, "go_press_idle");
    end
    game_over = 1'b0;
    repeat (3) cyc(3'b000, 1'b0, "go_press_settle");

    // reset asserted at HOLD count 10
    press_run(100, DEB + 3 + 10, "midrst_hold");
    key_n   = 1'b1;
    reset_n = 1'b0;
    #1;
    now_chk(3'b111, 1'b1, "midrst_async");
    cyc(3'b111, 1'b1, "midrst_low");
    cyc(3'b111, 1'b1, "midrst_low");
    reset_n = 1'b1;
    now_chk(3'b111, 1'b1, "midrst_release");
    cyc(3'b111, 1'b1, "midrst_pulse");
    cyc(3'b111, 1'b1, "midrst_pulse");
    cyc(3'b000, 1'b0, "midrst_end");
    repeat (4) cyc(3'b000, 1'b0, "midrst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
